// File: rtl/room_entry_detector.sv
// room_entry_detector
// Doorway walk-through decoder that feeds the room occupancy counter.
// Two beam sensors (outer, inner) are synchronized and optionally
// debounced. An FSM then recognises full entry and exit passes and
// turns each one into a single en/up request for the counter.
// Requests that would overflow (room full) or underflow (room empty)
// are turned into a reject pulse instead.
// Optional feature macro: ROOM_DEBOUNCE_EN
//   defined   : each channel must stay stable for DEBOUNCE cycles
//   undefined : the filtered value is the synchronized value
module room_entry_detector #(
    parameter int MAX_COUNT = 15,
    parameter int DEBOUNCE  = 4,
    parameter int TIMEOUT   = 1000,
    parameter int TCW       = 10
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       sensor_out,
    input  logic       sensor_in,
    input  logic [3:0] number,
    output logic       en,
    output logic       up,
    output logic       abort,
    output logic       reject,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE,
        E1,
        E2,
        E3,
        X1,
        X2,
        X3,
        WAIT_CLR
    } state_t;

    // Bit 1 carries the outer beam and bit 0 the inner beam throughout.
    logic [1:0]     sync1;
    logic [1:0]     sync2;
    logic [1:0]     filt;
    logic           o;
    logic           i;

    state_t         state;
    state_t         next_state;
    logic [TCW-1:0] dwell;
    logic           in_seq;
    logic           timeout_hit;

    logic           en_next;
    logic           abort_next;
    logic           reject_next;
    logic           up_next;

    // Parameter sanity checks evaluated at elaboration time.
    if (DEBOUNCE < 1) begin : g_bad_debounce
        $error("room_entry_detector: DEBOUNCE must be at least 1");
    end
    if (TIMEOUT < 2 || TIMEOUT > (2 ** TCW) - 1) begin : g_bad_timeout
        $error("room_entry_detector: TCW too narrow for TIMEOUT");
    end

    // Two-flop synchronizer bringing both raw beams into the clk domain.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {sensor_out, sensor_in};
            sync2 <= sync1;
        end
    end

`ifdef ROOM_DEBOUNCE_EN
    localparam int DBW = $clog2(DEBOUNCE + 1);

    logic [DBW-1:0] dcnt [2];

    // Per-channel debounce: accept a new level only after it has differed
    // from the filtered value for DEBOUNCE consecutive cycles.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            filt    <= '0;
            dcnt[0] <= '0;
            dcnt[1] <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (sync2[c] == filt[c]) begin
                    dcnt[c] <= '0;
                end else if (dcnt[c] == DBW'(DEBOUNCE - 1)) begin
                    filt[c] <= sync2[c];
                    dcnt[c] <= '0;
                end else begin
                    dcnt[c] <= dcnt[c] + 1'b1;
                end
            end
        end
    end
`else
    // Without debouncing the FSM sees the synchronized beams directly.
    always_comb begin
        filt = sync2;
    end
`endif

    assign o = filt[1];
    assign i = filt[0];

    // The dwell timer only runs inside an entry or exit sequence.
    always_comb begin
        in_seq      = (state != IDLE) && (state != WAIT_CLR);
        timeout_hit = in_seq && (dwell == TCW'(TIMEOUT - 1));
    end

    // Next-state decode plus the pulse outputs that accompany each move.
    always_comb begin
        next_state  = state;
        en_next     = 1'b0;
        abort_next  = 1'b0;
        reject_next = 1'b0;
        up_next     = up;

        case (state)
            IDLE: begin
                case ({o, i})
                    2'b10: next_state = E1;
                    2'b01: next_state = X1;
                    2'b11: begin
                        next_state = WAIT_CLR;
                        abort_next = 1'b1;
                    end
                    default: next_state = IDLE;
                endcase
            end
            E1: begin
                case ({o, i})
                    2'b11: next_state = E2;
                    2'b00: begin
                        next_state = IDLE;
                        abort_next = 1'b1;
                    end
                    2'b01: begin
                        next_state = WAIT_CLR;
                        abort_next = 1'b1;
                    end
                    default: next_state = E1;
                endcase
            end
            E2: begin
                case ({o, i})
                    2'b01: next_state = E3;
                    2'b10: next_state = E1;
                    2'b00: begin
                        next_state = IDLE;
                        abort_next = 1'b1;
                    end
                    default: next_state = E2;
                endcase
            end
            E3: begin
                case ({o, i})
                    2'b00: begin
                        next_state = IDLE;
                        if (number == 4'(MAX_COUNT)) begin
                            reject_next = 1'b1;
                        end else begin
                            en_next = 1'b1;
                            up_next = 1'b1;
                        end
                    end
                    2'b11: next_state = E2;
                    2'b10: begin
                        next_state = WAIT_CLR;
                        abort_next = 1'b1;
                    end
                    default: next_state = E3;
                endcase
            end
            X1: begin
                case ({o, i})
                    2'b11: next_state = X2;
                    2'b00: begin
                        next_state = IDLE;
                        abort_next = 1'b1;
                    end
                    2'b10: begin
                        next_state = WAIT_CLR;
                        abort_next = 1'b1;
                    end
                    default: next_state = X1;
                endcase
            end
            X2: begin
                case ({o, i})
                    2'b10: next_state = X3;
                    2'b01: next_state = X1;
                    2'b00: begin
                        next_state = IDLE;
                        abort_next = 1'b1;
                    end
                    default: next_state = X2;
                endcase
            end
            X3: begin
                case ({o, i})
                    2'b00: begin
                        next_state = IDLE;
                        if (number == 4'd0) begin
                            reject_next = 1'b1;
                        end else begin
                            en_next = 1'b1;
                            up_next = 1'b0;
                        end
                    end
                    2'b11: next_state = X2;
                    2'b01: begin
                        next_state = WAIT_CLR;
                        abort_next = 1'b1;
                    end
                    default: next_state = X3;
                endcase
            end
            WAIT_CLR: begin
                if ({o, i} == 2'b00) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase

        // A stalled sequence is abandoned even if the beams move this cycle.
        if (timeout_hit) begin
            next_state  = WAIT_CLR;
            abort_next  = 1'b1;
            en_next     = 1'b0;
            reject_next = 1'b0;
            up_next     = up;
        end
    end

    // State register with the registered pulse, direction and busy outputs.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state  <= IDLE;
            en     <= 1'b0;
            abort  <= 1'b0;
            reject <= 1'b0;
            up     <= 1'b1;
            busy   <= 1'b0;
        end else begin
            state  <= next_state;
            en     <= en_next;
            abort  <= abort_next;
            reject <= reject_next;
            up     <= up_next;
            busy   <= (next_state != IDLE);
        end
    end

    // Dwell timer restarts on every state change and idles outside sequences.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            dwell <= '0;
        end else if ((next_state != state) || !in_seq) begin
            dwell <= '0;
        end else begin
            dwell <= dwell + 1'b1;
        end
    end

endmodule

// File: tb/tb_room_entry_detector.sv
// tb_room_entry_detector
// Directed bench for room_entry_detector. Expected pulses are queued
// when a walk sequence is driven and compared as the DUT emits them.
// Honours ROOM_DEBOUNCE_EN for the glitch scenario.
module tb_room_entry_detector;

    localparam int TIMEOUT_CYC = 1000;

    typedef enum int {
        EV_EN     = 0,
        EV_ABORT  = 1,
        EV_REJECT = 2
    } ev_kind_t;

    typedef struct {
        ev_kind_t kind;
        logic     up;
        string    tag;
    } ev_t;

    ev_t        exp_q [$];

    logic       clk = 1'b0;
    logic       clr;
    logic       sensor_out;
    logic       sensor_in;
    logic [3:0] number;
    logic       en;
    logic       up;
    logic       abort;
    logic       reject;
    logic       busy;

    int         checks    = 0;
    int         errors    = 0;
    int         cyc       = 0;
    int         abort_cyc = 0;
    int         start_cyc = 0;
    logic       busy_seen = 1'b0;

    room_entry_detector dut (
        .clk        (clk),
        .clr        (clr),
        .sensor_out (sensor_out),
        .sensor_in  (sensor_in),
        .number     (number),
        .en         (en),
        .up         (up),
        .abort      (abort),
        .reject     (reject),
        .busy       (busy)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    // Cycle counter used to time the dwell timeout.
    always @(posedge clk) cyc++;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("[TB] %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expectEvent(input ev_kind_t k, input logic u, input string tag);
        ev_t e;
        e.kind = k;
        e.up   = u;
        e.tag  = tag;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic so, input logic si, input int n);
        sensor_out = so;
        sensor_in  = si;
        repeat (n) @(negedge clk);
    endtask

    // Scoreboard side: every pulse seen is matched against the oldest expectation.
    always @(negedge clk) begin : monitor
        ev_t e;
        int  k;
        if (busy === 1'b1) busy_seen = 1'b1;
        if (en === 1'b1 || abort === 1'b1 || reject === 1'b1) begin
            k = (en === 1'b1) ? EV_EN : ((abort === 1'b1) ? EV_ABORT : EV_REJECT);
            if (abort === 1'b1) abort_cyc = cyc;
            checkOutput("one_hot_pulse", 32'(int'(en) + int'(abort) + int'(reject)), 32'd1);
            checkOutput("pulse_was_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checkOutput({e.tag, "_kind"}, 32'(k), 32'(e.kind));
                if (e.kind == EV_EN) checkOutput({e.tag, "_up"}, 32'(up), 32'(e.up));
            end
        end
    end

    // Directed test sequence.
    initial begin
        clr        = 1'b0;
        sensor_out = 1'b0;
        sensor_in  = 1'b0;
        number     = 4'd3;

        repeat (3) @(negedge clk);
        checkOutput("rst_en", 32'(en), 32'd0);
        checkOutput("rst_abort", 32'(abort), 32'd0);
        checkOutput("rst_reject", 32'(reject), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_up", 32'(up), 32'd1);
        clr = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("post_rst_en", 32'(en), 32'd0);
        checkOutput("post_rst_busy", 32'(busy), 32'd0);
        checkOutput("post_rst_up", 32'(up), 32'd1);

        // Normal entry.
        number = 4'd3;
        expectEvent(EV_EN, 1'b1, "entry");
        applyStimulus(1'b1, 1'b0, 20);
        checkOutput("entry_busy_mid", 32'(busy), 32'd1);
        applyStimulus(1'b1, 1'b1, 20);
        applyStimulus(1'b0, 1'b1, 20);
        applyStimulus(1'b0, 1'b0, 20);
        checkOutput("entry_done", 32'(exp_q.size()), 32'd0);
        checkOutput("entry_busy_end", 32'(busy), 32'd0);

        // Normal exit; direction must stick afterwards.
        expectEvent(EV_EN, 1'b0, "exit");
        applyStimulus(1'b0, 1'b1, 20);
        applyStimulus(1'b1, 1'b1, 20);
        applyStimulus(1'b1, 1'b0, 20);
        applyStimulus(1'b0, 1'b0, 20);
        checkOutput("exit_done", 32'(exp_q.size()), 32'd0);
        checkOutput("exit_up_hold", 32'(up), 32'd0);

        // Entry while full is rejected.
        number = 4'd15;
        expectEvent(EV_REJECT, 1'b0, "full_entry");
        applyStimulus(1'b1, 1'b0, 20);
        applyStimulus(1'b1, 1'b1, 20);
        applyStimulus(1'b0, 1'b1, 20);
        applyStimulus(1'b0, 1'b0, 20);
        checkOutput("full_done", 32'(exp_q.size()), 32'd0);
        checkOutput("full_up_hold", 32'(up), 32'd0);

        // Exit while empty is rejected.
        number = 4'd0;
        expectEvent(EV_REJECT, 1'b0, "empty_exit");
        applyStimulus(1'b0, 1'b1, 20);
        applyStimulus(1'b1, 1'b1, 20);
        applyStimulus(1'b1, 1'b0, 20);
        applyStimulus(1'b0, 1'b0, 20);
        checkOutput("empty_done", 32'(exp_q.size()), 32'd0);

        // Entry with one below full still counts.
        number = 4'd14;
        expectEvent(EV_EN, 1'b1, "near_full_entry");
        applyStimulus(1'b1, 1'b0, 20);
        applyStimulus(1'b1, 1'b1, 20);
        applyStimulus(1'b0, 1'b1, 20);
        applyStimulus(1'b0, 1'b0, 20);
        checkOutput("near_full_done", 32'(exp_q.size()), 32'd0);
        checkOutput("near_full_up", 32'(up), 32'd1);

        // Person backs out of the doorway.
        number = 4'd3;
        expectEvent(EV_ABORT, 1'b0, "backout");
        applyStimulus(1'b1, 1'b0, 20);
        applyStimulus(1'b1, 1'b1, 20);
        applyStimulus(1'b1, 1'b0, 20);
        applyStimulus(1'b0, 1'b0, 20);
        checkOutput("backout_done", 32'(exp_q.size()), 32'd0);

        // Outer beam held too long: timeout abort, then wait for clear.
        expectEvent(EV_ABORT, 1'b0, "timeout");
        start_cyc = cyc;
        applyStimulus(1'b1, 1'b0, 1200);
        checkOutput("timeout_done", 32'(exp_q.size()), 32'd0);
        checkOutput("timeout_window",
                    32'(((abort_cyc - start_cyc) >= TIMEOUT_CYC) && ((abort_cyc - start_cyc) <= TIMEOUT_CYC + 12)),
                    32'd1);
        checkOutput("timeout_busy_held", 32'(busy), 32'd1);
        applyStimulus(1'b0, 1'b0, 20);
        checkOutput("timeout_released", 32'(busy), 32'd0);

        // Two-cycle glitch on the outer beam.
        busy_seen = 1'b0;
`ifndef ROOM_DEBOUNCE_EN
        expectEvent(EV_ABORT, 1'b0, "glitch");
`endif
        applyStimulus(1'b1, 1'b0, 2);
        applyStimulus(1'b0, 1'b0, 20);
        checkOutput("glitch_done", 32'(exp_q.size()), 32'd0);
`ifdef ROOM_DEBOUNCE_EN
        checkOutput("glitch_busy_seen", 32'(busy_seen), 32'd0);
`else
        checkOutput("glitch_busy_seen", 32'(busy_seen), 32'd1);
`endif

        // Asynchronous clear while in E2.
        applyStimulus(1'b1, 1'b0, 20);
        applyStimulus(1'b1, 1'b1, 20);
        checkOutput("e2_busy", 32'(busy), 32'd1);
        #2;
        clr = 1'b0;
        #1;
        checkOutput("async_clr_busy", 32'(busy), 32'd0);
        checkOutput("async_clr_en", 32'(en), 32'd0);
        checkOutput("async_clr_abort", 32'(abort), 32'd0);
        checkOutput("async_clr_up", 32'(up), 32'd1);
        sensor_out = 1'b0;
        sensor_in  = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        applyStimulus(1'b0, 1'b0, 20);
        checkOutput("async_clr_quiet", 32'(exp_q.size()), 32'd0);
        checkOutput("async_clr_idle", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
